// File: rtl/hwpe_dma_loader.sv
// Sequencer that copies fmap half 1, fmap half 2 and kernel words from a 64-bit
// source memory into the HWPE local SRAMs, one source read outstanding at a time.
module hwpe_dma_loader #(
  parameter int HWPE_ADDR_WIDTH = 16,
  parameter int ADDR_W          = HWPE_ADDR_WIDTH,
  parameter int SRC_AW          = 32,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SRC_AW-1:0] fmap_src_base,
  input  logic [SRC_AW-1:0] fmap2_src_base,
  input  logic [CNT_W-1:0]  fmap_words,
  input  logic [ADDR_W-1:0] fmap1_dst,
  input  logic [ADDR_W-1:0] fmap2_dst,
  input  logic [SRC_AW-1:0] kern_src_base,
  input  logic [ADDR_W-1:0] kern_dst,
  input  logic [CNT_W-1:0]  kern_words,
  output logic              src_req_valid,
  input  logic              src_req_ready,
  output logic [SRC_AW-1:0] src_req_addr,
  input  logic              src_rsp_valid,
  input  logic [63:0]       src_rsp_data,
  output logic              dma_wen,
  output logic [ADDR_W-1:0] dma_wa,
  output logic [63:0]       dma_wd,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_LAST, S_DONE} state_t;
  typedef enum logic [1:0] {P_F1, P_F2, P_KRN} phase_t;

  state_t            state_reg;
  phase_t            phase_reg;
  logic [SRC_AW-1:0] src_ptr_reg;
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [SRC_AW-1:0] f2_src_reg;
  logic [ADDR_W-1:0] f2_dst_reg;
  logic [SRC_AW-1:0] k_src_reg;
  logic [ADDR_W-1:0] k_dst_reg;
  logic [CNT_W-1:0]  fmap_words_reg;
  logic [CNT_W-1:0]  kern_words_reg;
  logic              req_valid_reg;
  logic              wen_reg;
  logic [ADDR_W-1:0] wa_reg;
  logic [63:0]       wd_reg;
  logic              busy_reg;
  logic              done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      phase_reg      <= P_F1;
      src_ptr_reg    <= '0;
      dst_ptr_reg    <= '0;
      cnt_reg        <= '0;
      f2_src_reg     <= '0;
      f2_dst_reg     <= '0;
      k_src_reg      <= '0;
      k_dst_reg      <= '0;
      fmap_words_reg <= '0;
      kern_words_reg <= '0;
      req_valid_reg  <= 1'b0;
      wen_reg        <= 1'b0;
      wa_reg         <= '0;
      wd_reg         <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      wen_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            f2_src_reg     <= fmap2_src_base;
            f2_dst_reg     <= fmap2_dst;
            k_src_reg      <= kern_src_base;
            k_dst_reg      <= kern_dst;
            fmap_words_reg <= fmap_words;
            kern_words_reg <= kern_words;
            busy_reg       <= 1'b1;
            // Empty phases are skipped right here so the first request goes out next cycle.
            if (fmap_words != '0) begin
              phase_reg     <= P_F1;
              src_ptr_reg   <= fmap_src_base;
              dst_ptr_reg   <= fmap1_dst;
              cnt_reg       <= fmap_words;
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end else if (kern_words != '0) begin
              phase_reg     <= P_KRN;
              src_ptr_reg   <= kern_src_base;
              dst_ptr_reg   <= kern_dst;
              cnt_reg       <= kern_words;
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end else begin
              state_reg <= S_LAST;
            end
          end
        end
        S_REQ: begin
          if (src_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (src_rsp_valid) begin
            wen_reg <= 1'b1;
            wa_reg  <= dst_ptr_reg;
            wd_reg  <= src_rsp_data;
            if (cnt_reg != CNT_W'(1)) begin
              src_ptr_reg   <= src_ptr_reg + SRC_AW'(8);
              dst_ptr_reg   <= dst_ptr_reg + ADDR_W'(8);
              cnt_reg       <= cnt_reg - CNT_W'(1);
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end else if (phase_reg == P_F1) begin
              // F1 was non-empty, so F2 (same word count) is too.
              phase_reg     <= P_F2;
              src_ptr_reg   <= f2_src_reg;
              dst_ptr_reg   <= f2_dst_reg;
              cnt_reg       <= fmap_words_reg;
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end else if (phase_reg == P_F2 && kern_words_reg != '0) begin
              phase_reg     <= P_KRN;
              src_ptr_reg   <= k_src_reg;
              dst_ptr_reg   <= k_dst_reg;
              cnt_reg       <= kern_words_reg;
              req_valid_reg <= 1'b1;
              state_reg     <= S_REQ;
            end else begin
              cnt_reg   <= '0;
              state_reg <= S_LAST;
            end
          end
        end
        S_LAST: begin
          // One cycle after the final write lands, so done trails the last dma_wen.
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign src_req_valid = req_valid_reg;
  assign src_req_addr  = src_ptr_reg;
  assign dma_wen       = wen_reg;
  assign dma_wa        = wa_reg;
  assign dma_wd        = wd_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
